fft_reorder: RTL and testbench
==============================

# fft_reorder

Bit-reversal reorder buffer for the radix-2^2 SDF FFT pipeline. It consumes the SDF output stream, which arrives in bit-reversed bin order, and re-emits each N-point frame in natural bin order (bin 0 first). It sits directly after the last SDF stage and uses a ping-pong pair of N-entry banks, so back-to-back frames stream with no stall and no overrun.

## Interface
- N, 64: FFT points per frame; power of 2, N >= 4; LOG_N = log2(N).
- WIDTH, 16: data bit length per real/imag component.

- clock  in  1  master clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- di_en  in  1  input sample valid; one sample accepted per clock while high.
- di_re  in  WIDTH  input sample, real part, bit-reversed order.
- di_im  in  WIDTH  input sample, imag part, bit-reversed order.
- do_en  out  1  output sample valid.
- do_re  out  WIDTH  output sample, real part, natural order.
- do_im  out  WIDTH  output sample, imag part, natural order.
- do_idx  out  LOG_N  natural bin index of the current output; present only with FFT_REORDER_INDEX_EN.

## Operation
- Storage: two banks (bank 0, bank 1) of N x 2*WIDTH. Synchronous write, synchronous read. Contents are not reset.
- Write side:
  - wr_cnt (LOG_N bits) and wr_bank (1 bit).
  - Each clock with di_en=1: write {di_re, di_im} to bank wr_bank at address bitrev(wr_cnt), where bitrev reverses all LOG_N bits. Then increment wr_cnt.
  - di_en=0 pauses the frame: wr_cnt holds. Gaps inside a frame are allowed; frame boundaries are defined only by the count.
  - Frame complete: a write with wr_cnt = N-1. On that edge wr_cnt wraps to 0, wr_bank toggles, and a read of the just-filled bank is launched.
- Read side FSM, states IDLE and READ:
  - IDLE -> READ on the frame-complete edge: rd_bank <= old wr_bank, rd_cnt <= 0.
  - In READ: read address rd_cnt in bank rd_bank each cycle, rd_cnt++.
  - READ -> IDLE after rd_cnt = N-1 is issued, unless another frame completes on that same edge. In that case the FSM stays in READ with rd_cnt <= 0 and rd_bank toggled.
  - A frame-complete edge can occur at the earliest on the edge that issues read address N-1, so there is no overrun. The read of bank B begins on the cycle immediately after bank A's last read, and output remains contiguous.
- Read pipeline: memory read register, then output register. Two stages in total.
- Data is passed through bit-exact. No arithmetic is performed.

## Timing
- Reset values: do_en=0, do_re=0, do_im=0, do_idx=0; wr_cnt=0, wr_bank=0, FSM=IDLE, rd_cnt=0, rd_bank=0.
- Latency: edge E captures input sample N-1 of a frame. Output bin 0 is driven after edge E+2, so do_en is high during the cycle following E+2. Bin k is driven after edge E+2+k. do_en stays high for exactly N consecutive cycles per frame.
- Contiguous input frames give contiguous output, with no do_en gap at the frame seam.
- When do_en=0, do_re and do_im hold their last value.
- Reset mid-operation:
  - The partial write frame is discarded and the in-flight read is aborted.
  - do_en drops asynchronously.
  - The first frame after reset release starts at wr_cnt=0 into bank 0.
- Reset asserted during a di_en cycle: that sample is not written.

## Configuration
- FFT_REORDER_INDEX_EN defined:
  - The do_idx port exists.
  - do_idx carries rd_cnt delayed through both pipeline stages, so it equals the natural bin index aligned with do_re/do_im.
  - It resets to 0 and holds when do_en=0.
- FFT_REORDER_INDEX_EN undefined: the do_idx port and its pipeline registers are absent. All other behaviour is identical.

## Test plan
- N=64 single frame:
  - Stimulus: 64 contiguous samples; sample i has re = bitrev6(i), im = -bitrev6(i).
  - Required: do_en high for 64 cycles starting 2 cycles after the last input edge; output k has re = k, im = -k.
- Three back-to-back frames with contiguous di_en, each frame tagged in the upper bits:
  - Required: 192 contiguous do_en cycles; frames emitted in order; each frame in natural order.
- Gapped input: di_en toggles 1/0 through one frame (127 cycles).
  - Required: same natural-order output as the contiguous case, starting 2 cycles after the 64th accepted sample.
- Reset mid-frame:
  - Stimulus: assert reset after input sample 30 of a frame and during the read of the previous frame.
  - Required: do_en=0 and do_re/do_im=0 immediately. A following full frame is output correctly with no leftover samples.
- N=16 build with FFT_REORDER_INDEX_EN defined:
  - Stimulus: one frame.
  - Required: do_idx runs 0..15 aligned with data re = 0..15; do_idx = 0 after reset.

Source files
------------

// File: rtl/fft_reorder_if.sv
// Stream bundle for fft_reorder: bit-reversed input, natural-order output.
// do_idx exists only when FFT_REORDER_INDEX_EN is defined.
interface fft_reorder_if #(
  parameter int N     = 64,
  parameter int WIDTH = 16
);
  localparam int LOG_N = $clog2(N);

  logic             di_en;
  logic [WIDTH-1:0] di_re;
  logic [WIDTH-1:0] di_im;
  logic             do_en;
  logic [WIDTH-1:0] do_re;
  logic [WIDTH-1:0] do_im;
`ifdef FFT_REORDER_INDEX_EN
  logic [LOG_N-1:0] do_idx;

  modport master (output di_en, di_re, di_im, input do_en, do_re, do_im, do_idx);
  modport slave  (input di_en, di_re, di_im, output do_en, do_re, do_im, do_idx);
`else
  modport master (output di_en, di_re, di_im, input do_en, do_re, do_im);
  modport slave  (input di_en, di_re, di_im, output do_en, do_re, do_im);
`endif
endinterface

// File: rtl/fft_reorder.sv
// Ping-pong bit-reversal reorder buffer: bit-reversed SDF output in, natural order out.
// Optional do_idx output enabled by FFT_REORDER_INDEX_EN.
module fft_reorder #(
  parameter int N     = 64,
  parameter int WIDTH = 16
) (
  input  logic          clock,
  input  logic          reset,
  fft_reorder_if.slave  s
);
  localparam int LOG_N = $clog2(N);

  typedef enum logic {IDLE, READ} state_t;

  function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] v);
    logic [LOG_N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LOG_N; i++) r[i] = v[LOG_N-1-i];
    return r;
  endfunction

  logic [2*WIDTH-1:0] bank0_q [N];
  logic [2*WIDTH-1:0] bank1_q [N];
  logic [2*WIDTH-1:0] rd_data_q;

  logic [LOG_N-1:0] wr_cnt_q, wr_cnt_d;
  logic             wr_bank_q, wr_bank_d;
  state_t           state_q, state_d;
  logic [LOG_N-1:0] rd_cnt_q, rd_cnt_d;
  logic             rd_bank_q, rd_bank_d;
  logic             rd_vld_q, rd_vld_d;
  logic             do_en_q, do_en_d;
  logic [WIDTH-1:0] do_re_q, do_re_d;
  logic [WIDTH-1:0] do_im_q, do_im_d;

  logic             wr_we;
  logic             frame_done;
  logic [LOG_N-1:0] wr_addr;

  // A sample presented while reset is asserted must not land in the banks.
  assign wr_we      = s.di_en && !reset;
  assign wr_addr    = bitrev(wr_cnt_q);
  assign frame_done = s.di_en && (wr_cnt_q == '1);

  always_ff @(posedge clock) begin
    if (wr_we && !wr_bank_q) bank0_q[wr_addr] <= {s.di_re, s.di_im};
    if (wr_we &&  wr_bank_q) bank1_q[wr_addr] <= {s.di_re, s.di_im};
    if (state_q == READ)
      rd_data_q <= rd_bank_q ? bank1_q[rd_cnt_q] : bank0_q[rd_cnt_q];
  end

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;

    if (s.di_en) wr_cnt_d = wr_cnt_q + 1'b1;
    if (frame_done) wr_bank_d = ~wr_bank_q;

    if (state_q == READ) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
      if (rd_cnt_q == '1) state_d = IDLE;
    end
    // A frame completing on the last-read edge restarts on the other bank seamlessly.
    if (frame_done) begin
      state_d   = READ;
      rd_cnt_d  = '0;
      rd_bank_d = wr_bank_q;
    end

    rd_vld_d = (state_q == READ);
    do_en_d  = rd_vld_q;
    do_re_d  = do_re_q;
    do_im_d  = do_im_q;
    if (rd_vld_q) {do_re_d, do_im_d} = rd_data_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      state_q   <= IDLE;
      rd_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      do_en_q   <= 1'b0;
      do_re_q   <= '0;
      do_im_q   <= '0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      wr_bank_q <= wr_bank_d;
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_bank_q <= rd_bank_d;
      rd_vld_q  <= rd_vld_d;
      do_en_q   <= do_en_d;
      do_re_q   <= do_re_d;
      do_im_q   <= do_im_d;
    end
  end

  assign s.do_en = do_en_q;
  assign s.do_re = do_re_q;
  assign s.do_im = do_im_q;

`ifdef FFT_REORDER_INDEX_EN
  logic [LOG_N-1:0] rd_idx_q, rd_idx_d;
  logic [LOG_N-1:0] do_idx_q, do_idx_d;

  always_comb begin
    rd_idx_d = rd_cnt_q;
    do_idx_d = rd_vld_q ? rd_idx_q : do_idx_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_idx_q <= '0;
      do_idx_q <= '0;
    end else begin
      rd_idx_q <= rd_idx_d;
      do_idx_q <= do_idx_d;
    end
  end

  assign s.do_idx = do_idx_q;
`endif
endmodule

// File: tb/tb_fft_reorder.sv
// Self-checking bench for fft_reorder: frame-level scoreboard plus literal spot checks.
// N=16 when FFT_REORDER_INDEX_EN is defined (index build), N=64 otherwise.
module tb_fft_reorder;
`ifdef FFT_REORDER_INDEX_EN
  localparam int N = 16;
`else
  localparam int N = 64;
`endif
  localparam int WIDTH = 16;
  localparam int LOG_N = $clog2(N);

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fft_reorder_if #(.N(N), .WIDTH(WIDTH)) bus ();
  fft_reorder #(.N(N), .WIDTH(WIDTH)) dut (.clock(clock), .reset(reset), .s(bus.slave));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rev(input int v);
    int r = 0;
    for (int i = 0; i < LOG_N; i++) if (v[i]) r |= 1 << (LOG_N - 1 - i);
    return r;
  endfunction

  // Behavioural model: collect a frame in arrival order; once N samples are in,
  // natural bin k is arrival sample rev(k), due on edge (completion + 2 + k).
  typedef struct {
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
    int               idx;
    longint           due;
  } exp_t;

  exp_t             q[$];
  logic [WIDTH-1:0] fr_re [N];
  logic [WIDTH-1:0] fr_im [N];
  int               fr_cnt = 0;
  longint           cyc = 0;
  logic [WIDTH-1:0] last_re = '0;
  logic [WIDTH-1:0] last_im = '0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      q.delete();
      fr_cnt  = 0;
      last_re = '0;
      last_im = '0;
    end else begin
      cyc++;
      if (bus.di_en) begin
        fr_re[fr_cnt] = bus.di_re;
        fr_im[fr_cnt] = bus.di_im;
        fr_cnt++;
        if (fr_cnt == N) begin
          for (int k = 0; k < N; k++) begin
            exp_t e;
            e.re  = fr_re[rev(k)];
            e.im  = fr_im[rev(k)];
            e.idx = k;
            e.due = cyc + 2 + k;
            q.push_back(e);
          end
          fr_cnt = 0;
        end
      end
    end
  end

  always @(negedge clock) begin
    logic exp_en;
    exp_en = (q.size() > 0) && (q[0].due == cyc);
    if (q.size() > 0) chk("sched_not_missed", 64'(q[0].due < cyc), 64'(0));
    chk("do_en", 64'(bus.do_en), 64'(exp_en));
    if (exp_en) begin
      chk("do_re", 64'(bus.do_re), 64'(q[0].re));
      chk("do_im", 64'(bus.do_im), 64'(q[0].im));
`ifdef FFT_REORDER_INDEX_EN
      chk("do_idx", 64'(bus.do_idx), 64'(q[0].idx));
`endif
      last_re = q[0].re;
      last_im = q[0].im;
      void'(q.pop_front());
    end else begin
      chk("hold_re", 64'(bus.do_re), 64'(last_re));
      chk("hold_im", 64'(bus.do_im), 64'(last_im));
    end
  end

  task automatic send(input int re, input int im);
    @(negedge clock);
    bus.di_en = 1'b1;
    bus.di_re = WIDTH'(re);
    bus.di_im = WIDTH'(im);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      bus.di_en = 1'b0;
    end
  endtask

  initial begin
    bus.di_en = 1'b0;
    bus.di_re = '0;
    bus.di_im = '0;
    repeat (3) @(negedge clock);
    chk("rst_do_en", 64'(bus.do_en), 64'(0));
    chk("rst_do_re", 64'(bus.do_re), 64'(0));
    chk("rst_do_im", 64'(bus.do_im), 64'(0));
`ifdef FFT_REORDER_INDEX_EN
    chk("rst_do_idx", 64'(bus.do_idx), 64'(0));
`endif
    reset = 1'b0;
    idle(2);

    // Single frame: re = rev(i), im = -rev(i) -> output k is (k, -k).
    for (int i = 0; i < N; i++) send(rev(i), -rev(i));
    @(negedge clock); bus.di_en = 1'b0;
    chk("lat_after_e", 64'(bus.do_en), 64'(0));
    @(negedge clock);
    chk("lat_after_e1", 64'(bus.do_en), 64'(0));
    @(negedge clock);
    chk("lat_after_e2_en", 64'(bus.do_en), 64'(1));
    chk("bin0_re", 64'(bus.do_re), 64'(0));
    chk("bin0_im", 64'(bus.do_im), 64'(0));
    repeat (5) @(negedge clock);
    chk("bin5_re", 64'(bus.do_re), 64'(5));
    chk("bin5_im", 64'(bus.do_im), 64'(16'hFFFB));
`ifdef FFT_REORDER_INDEX_EN
    chk("bin5_idx", 64'(bus.do_idx), 64'(5));
`endif
    idle(N + 4);
    chk("frame1_drained_en", 64'(bus.do_en), 64'(0));
    chk("frame1_last_re", 64'(bus.do_re), 64'(N - 1));

    // Three contiguous frames, tagged in the upper bits.
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < N; i++) send(((f + 1) << (LOG_N + 1)) | i, ~(((f + 1) << (LOG_N + 1)) | i));
    idle(N + 8);

    // Gapped input: valid every other cycle, 2N-1 cycles in total.
    for (int i = 0; i < N; i++) begin
      send(16'h0300 + 3 * i, 16'h0500 - i);
      if (i < N - 1) idle(1);
    end
    idle(N + 8);

    // Reset with a partial frame in flight and the previous frame mid-read.
    for (int i = 0; i < N; i++) send(16'h0100 + i, 16'h7000 + i);
    for (int i = 0; i < N / 2 - 1; i++) send(16'h0A00 + i, 16'h0B00 + i);
    send(16'h0AFF, 16'h0BFF);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_en", 64'(bus.do_en), 64'(0));
    chk("async_rst_re", 64'(bus.do_re), 64'(0));
    chk("async_rst_im", 64'(bus.do_im), 64'(0));
    idle(3);
    reset = 1'b0;
    idle(2);
    for (int i = 0; i < N; i++) send(16'h0200 + i, 16'h0C00 + i);
    @(negedge clock); bus.di_en = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("post_rst_bin0_re", 64'(bus.do_re), 64'(16'h0200));
    idle(N + 8);

    chk("scoreboard_drained", 64'(q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
